sample_serializer: RTL and testbench

Downstream consumer of the file-source stage. Takes one row of IN_NUM parallel signed samples and emits them one per beat on a single-sample stream, element 0 first. A valid/ready handshake is used on both sides. Sits between multi-lane test or DSP sources and single-lane processing blocks such as filters and file sinks.

---
 rtl/sample_serializer_if.sv | 28 ++
 rtl/sample_serializer.sv | 106 ++++++++++
 tb/tb_sample_serializer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sample_serializer_if.sv
// Handshake bundle around the sample serializer: a parallel frame input side
// and a single-sample output stream, each with valid/ready.
//   inValid/inReady/dataIn       : frame input (dataIn[0] is emitted first)
//   outValid/outReady/dataOut/outLast : serialized sample stream
// master: the surrounding environment (frame source + stream sink).
// slave : the serializer itself.
interface sample_serializer_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned IN_NUM = 8
);
  logic                           inValid;
  logic                           inReady;
  logic [IN_NUM-1:0][WIDTH-1:0]   dataIn;
  logic                           outValid;
  logic                           outReady;
  logic [WIDTH-1:0]               dataOut;
  logic                           outLast;

  modport master (
    output inValid, dataIn, outReady,
    input  inReady, outValid, dataOut, outLast
  );

  modport slave (
    input  inValid, dataIn, outReady,
    output inReady, outValid, dataOut, outLast
  );
endinterface

// File: rtl/sample_serializer.sv
// Serializes one row of IN_NUM signed samples into a single-sample stream,
// element 0 first, with a 1-cycle accept-to-first-beat latency and no bubble
// between back-to-back frames.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : sample_serializer_if.slave (frame in, sample stream out)
// inReady is combinational (depends on outReady) so a new frame can be taken
// on the same edge the last beat of the current frame leaves.
module sample_serializer #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned IN_NUM = 8
) (
  input  logic               clk,
  input  logic               rst,
  sample_serializer_if.slave bus
);

  localparam int unsigned IDX_W = (IN_NUM > 1) ? $clog2(IN_NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_NUM - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [IN_NUM-1:0][WIDTH-1:0] frame_q;

  logic                         out_valid_q, out_valid_d;
  logic                         out_last_q, out_last_d;
  logic [WIDTH-1:0]             data_out_q, data_out_d;

  logic                         in_ready_c;
  logic                         load_c;
  logic                         fire_out_c;
  logic                         at_last_c;
  logic [IDX_W-1:0]             idx_inc_c;

  // Handshake terms shared by the next-state and output logic.
  assign fire_out_c = out_valid_q && bus.outReady;
  assign at_last_c  = (idx_q == LAST_IDX);
  assign idx_inc_c  = idx_q + IDX_W'(1);
  assign in_ready_c = (state_q == EMPTY) || (fire_out_c && at_last_c);
  assign load_c     = bus.inValid && in_ready_c;

  // State, index, frame and registered stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      idx_q       <= '0;
      frame_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      data_out_q  <= data_out_d;
      if (load_c) begin
        frame_q <= bus.dataIn;
      end
    end
  end

  // Next state: a load always restarts at element 0, even while the last
  // beat of the previous frame is leaving.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (load_c) begin
      state_d = SHIFT;
      idx_d   = '0;
    end else if (fire_out_c && !at_last_c) begin
      idx_d   = idx_inc_c;
    end else if (fire_out_c && at_last_c) begin
      state_d = EMPTY;
      idx_d   = '0;
    end
  end

  // Next values of the registered outputs; dataOut holds when nothing moves.
  always_comb begin
    out_valid_d = (state_d == SHIFT);
    out_last_d  = out_last_q;
    data_out_d  = data_out_q;
    if (load_c) begin
      data_out_d = bus.dataIn[0];
      out_last_d = (IN_NUM == 1);
    end else if (fire_out_c && !at_last_c) begin
      data_out_d = frame_q[idx_inc_c];
      out_last_d = (idx_inc_c == LAST_IDX);
    end else if (fire_out_c && at_last_c) begin
      out_last_d = 1'b0;
    end
  end

  assign bus.inReady  = in_ready_c;
  assign bus.outValid = out_valid_q;
  assign bus.outLast  = out_last_q;
  assign bus.dataOut  = data_out_q;

endmodule

// File: tb/tb_sample_serializer.sv
// Directed bench for sample_serializer: an 8-lane/16-bit instance and a
// 1-lane/8-bit instance sharing clock and reset.
module tb_sample_serializer;

  logic clk;
  logic rst;

  int n_cmp;
  int n_err;

  sample_serializer_if #(.WIDTH(16), .IN_NUM(8)) bus8 ();
  sample_serializer_if #(.WIDTH(8),  .IN_NUM(1)) bus1 ();

  sample_serializer #(.WIDTH(16), .IN_NUM(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  sample_serializer #(.WIDTH(8), .IN_NUM(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_frame(input int base);
    for (int i = 0; i < 8; i++) bus8.dataIn[i] = 16'(base + i);
  endtask

  // Check one presented beat of the 8-lane instance.
  task automatic beat8(input string tag, input logic [15:0] data, input logic last);
    check({tag, ".valid"}, 32'(bus8.outValid), 32'd1);
    check({tag, ".data"},  32'(bus8.dataOut),  32'(data));
    check({tag, ".last"},  32'(bus8.outLast),  32'(last));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    bus8.inValid = 1'b0;
    bus8.outReady = 1'b0;
    bus8.dataIn = '0;
    bus1.inValid = 1'b0;
    bus1.outReady = 1'b0;
    bus1.dataIn = '0;

    // Reset asserted between edges takes effect at once.
    #12 rst = 1'b1;
    #1;
    check("rst.valid", 32'(bus8.outValid), 32'd0);
    check("rst.last",  32'(bus8.outLast),  32'd0);
    check("rst.data",  32'(bus8.dataOut),  32'd0);
    check("rst.valid1", 32'(bus1.outValid), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst.inready", 32'(bus8.inReady), 32'd1);

    // Single frame 0..7.
    set_frame(0);
    bus8.inValid = 1'b1;
    bus8.outReady = 1'b1;
    #1;
    check("single.inready", 32'(bus8.inReady), 32'd1);
    tick();
    bus8.inValid = 1'b0;
    set_frame(100);
    for (int k = 0; k < 8; k++) begin
      beat8($sformatf("single.b%0d", k), 16'(k), k == 7);
      tick();
    end
    check("single.idle", 32'(bus8.outValid), 32'd0);

    // Back-to-back: 0..7 then -8..-1 with no gap.
    set_frame(0);
    bus8.inValid = 1'b1;
    tick();
    set_frame(-8);
    for (int b = 0; b < 16; b++) begin
      beat8($sformatf("b2b.b%0d", b),
            (b < 8) ? 16'(b) : 16'(16'hFFF8 + 16'(b - 8)), (b % 8) == 7);
      check($sformatf("b2b.inready%0d", b), 32'(bus8.inReady), 32'((b % 8) == 7));
      tick();
      if (b == 7) bus8.inValid = 1'b0;
    end
    check("b2b.idle", 32'(bus8.outValid), 32'd0);

    // Backpressure at idx 3 with a second frame (40..47) pending.
    set_frame(0);
    bus8.inValid = 1'b1;
    tick();
    set_frame(40);
    for (int k = 0; k < 3; k++) begin
      beat8($sformatf("bp.b%0d", k), 16'(k), 1'b0);
      tick();
    end
    bus8.outReady = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      beat8($sformatf("bp.hold%0d", c), 16'd3, 1'b0);
      check($sformatf("bp.inready%0d", c), 32'(bus8.inReady), 32'd0);
      tick();
    end
    bus8.outReady = 1'b1;
    #1;
    beat8("bp.hold3", 16'd3, 1'b0);
    check("bp.inready3", 32'(bus8.inReady), 32'd0);
    tick();
    for (int k = 4; k < 8; k++) begin
      beat8($sformatf("bp.b%0d", k), 16'(k), k == 7);
      tick();
    end
    bus8.inValid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      beat8($sformatf("bp.n%0d", k), 16'(40 + k), k == 7);
      tick();
    end
    check("bp.idle", 32'(bus8.outValid), 32'd0);

    // Reset in the middle of frame 10..17.
    set_frame(10);
    bus8.inValid = 1'b1;
    tick();
    bus8.inValid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      beat8($sformatf("mrst.b%0d", k), 16'(10 + k), 1'b0);
      tick();
    end
    rst = 1'b1;
    #1;
    check("mrst.valid", 32'(bus8.outValid), 32'd0);
    check("mrst.data",  32'(bus8.dataOut),  32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("mrst.inready", 32'(bus8.inReady), 32'd1);
    set_frame(20);
    bus8.inValid = 1'b1;
    tick();
    bus8.inValid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      beat8($sformatf("mrst.n%0d", k), 16'(20 + k), k == 7);
      tick();
    end
    check("mrst.idle", 32'(bus8.outValid), 32'd0);

    // Single-lane pass-through: 0x80, 0x7F, 0x00 on consecutive cycles.
    bus1.outReady = 1'b1;
    bus1.inValid = 1'b1;
    bus1.dataIn[0] = 8'h80;
    #1;
    check("one.inready0", 32'(bus1.inReady), 32'd1);
    tick();
    check("one.d0", 32'(bus1.dataOut), 32'h80);
    check("one.l0", 32'(bus1.outLast), 32'd1);
    check("one.v0", 32'(bus1.outValid), 32'd1);
    bus1.dataIn[0] = 8'h7F;
    tick();
    check("one.d1", 32'(bus1.dataOut), 32'h7F);
    check("one.l1", 32'(bus1.outLast), 32'd1);
    bus1.dataIn[0] = 8'h00;
    tick();
    check("one.d2", 32'(bus1.dataOut), 32'h00);
    check("one.l2", 32'(bus1.outLast), 32'd1);
    check("one.v2", 32'(bus1.outValid), 32'd1);
    bus1.inValid = 1'b0;
    bus1.outReady = 1'b0;
    #1;
    check("one.rdy_lo", 32'(bus1.inReady), 32'd0);
    tick();
    check("one.hold", 32'(bus1.dataOut), 32'h00);
    check("one.hold_v", 32'(bus1.outValid), 32'd1);
    bus1.outReady = 1'b1;
    #1;
    check("one.rdy_hi", 32'(bus1.inReady), 32'd1);
    tick();
    check("one.idle", 32'(bus1.outValid), 32'd0);
    check("one.idle_rdy", 32'(bus1.inReady), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
